// File: rtl/iir.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module      : iir                                                      |
// | Description : Multi-cycle direct-form IIR filter between two FIFOs.    |
// |               One multiply-accumulate per tap per cycle, then a        |
// |               handshake-gated write of the accumulated sample.         |
// |               Optional macro IIR_SATURATE_EN clamps the written value  |
// |               to the signed 16-bit range.                              |
// | Revision    : 1.0  initial release                                     |
// +------------------------------------------------------------------------+
module iir #(
  parameter int DATA_SIZE  = 32,
  parameter int TAPS       = 2,
  parameter int QUANT_BITS = 10,
  parameter logic [0:TAPS-1][DATA_SIZE-1:0] X_COEFF = {32'h000000B2, 32'h000000B2},
  parameter logic [0:TAPS-1][DATA_SIZE-1:0] Y_COEFF = {32'h00000000, 32'hFFFFFD66}
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic [DATA_SIZE-1:0] x_in,
  input  logic                 x_empty,
  output logic                 x_rd_en,
  output logic [DATA_SIZE-1:0] y_out,
  input  logic                 y_out_full,
  output logic                 y_wr_en
);

  localparam int               TAP_W      = (TAPS > 1) ? $clog2(TAPS) : 1;
  localparam logic [TAP_W-1:0] C_LAST_TAP = TAP_W'(TAPS - 1);

  typedef enum logic [1:0] {
    S_READ    = 2'd0,
    S_COMPUTE = 2'd1,
    S_WRITE   = 2'd2
  } state_t;

  state_t                         r_state,   w_state_nxt;
  logic [0:TAPS-1][DATA_SIZE-1:0] r_x_hist,  w_x_hist_nxt;
  logic [0:TAPS-1][DATA_SIZE-1:0] r_y_hist,  w_y_hist_nxt;
  logic [DATA_SIZE-1:0]           r_acc,     w_acc_nxt;
  logic [DATA_SIZE-1:0]           r_y_out,   w_y_out_nxt;
  logic [TAP_W-1:0]               r_tap,     w_tap_nxt;
  logic                           r_y_wr_en, w_y_wr_en_nxt;

  logic signed [DATA_SIZE-1:0] w_x_prod;
  logic signed [DATA_SIZE-1:0] w_y_prod;
  logic signed [DATA_SIZE-1:0] w_x_term;
  logic signed [DATA_SIZE-1:0] w_y_term;
  logic signed [DATA_SIZE-1:0] w_wr_val;

  // Fixed-point rescale that rounds toward zero (symmetric for +/- values)
  function automatic logic signed [DATA_SIZE-1:0] deq(input logic signed [DATA_SIZE-1:0] v);
    if (v[DATA_SIZE-1]) deq = -((-v) >>> QUANT_BITS);
    else                deq = v >>> QUANT_BITS;
  endfunction

  // Products keep only the low DATA_SIZE bits before rescaling
  assign w_x_prod = $signed(X_COEFF[r_tap]) * $signed(r_x_hist[r_tap]);
  assign w_y_prod = $signed(Y_COEFF[r_tap]) * $signed(r_y_hist[r_tap]);
  assign w_x_term = deq(w_x_prod);
  assign w_y_term = (r_tap == '0) ? '0 : deq(w_y_prod);

`ifdef IIR_SATURATE_EN
  localparam logic signed [DATA_SIZE-1:0] C_SAT_MAX = DATA_SIZE'(32767);
  localparam logic signed [DATA_SIZE-1:0] C_SAT_MIN = DATA_SIZE'(-32768);

  // Clamp the accumulator to the signed 16-bit range on the way out
  always_comb begin
    if ($signed(r_acc) > C_SAT_MAX)      w_wr_val = C_SAT_MAX;
    else if ($signed(r_acc) < C_SAT_MIN) w_wr_val = C_SAT_MIN;
    else                                 w_wr_val = $signed(r_acc);
  end
`else
  assign w_wr_val = $signed(r_acc);
`endif

  // Next-state, datapath and upstream pop; everything holds by default
  always_comb begin
    w_state_nxt   = r_state;
    w_x_hist_nxt  = r_x_hist;
    w_y_hist_nxt  = r_y_hist;
    w_acc_nxt     = r_acc;
    w_y_out_nxt   = r_y_out;
    w_tap_nxt     = r_tap;
    w_y_wr_en_nxt = 1'b0;
    x_rd_en       = 1'b0;
    case (r_state)
      S_READ: begin
        if (!x_empty) begin
          x_rd_en         = !reset;
          w_x_hist_nxt[0] = x_in;
          for (int i = 1; i < TAPS; i++) w_x_hist_nxt[i] = r_x_hist[i-1];
          w_acc_nxt       = '0;
          w_tap_nxt       = '0;
          w_state_nxt     = S_COMPUTE;
        end
      end
      S_COMPUTE: begin
        w_acc_nxt = r_acc + w_x_term + w_y_term;
        if (r_tap == C_LAST_TAP) begin
          w_tap_nxt   = '0;
          w_state_nxt = S_WRITE;
        end else begin
          w_tap_nxt   = r_tap + 1'b1;
        end
      end
      S_WRITE: begin
        if (!y_out_full) begin
          w_y_out_nxt   = w_wr_val;
          w_y_wr_en_nxt = 1'b1;
          // Slot 0 of the feedback history is never used
          for (int i = 1; i < TAPS; i++)
            w_y_hist_nxt[i] = (i == 1) ? w_wr_val : r_y_hist[i-1];
          w_state_nxt   = S_READ;
        end
      end
      default: w_state_nxt = S_READ;
    endcase
  end

  // State register with synchronous reset clearing all history
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state   <= S_READ;
      r_x_hist  <= '0;
      r_y_hist  <= '0;
      r_acc     <= '0;
      r_y_out   <= '0;
      r_tap     <= '0;
      r_y_wr_en <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_x_hist  <= w_x_hist_nxt;
      r_y_hist  <= w_y_hist_nxt;
      r_acc     <= w_acc_nxt;
      r_y_out   <= w_y_out_nxt;
      r_tap     <= w_tap_nxt;
      r_y_wr_en <= w_y_wr_en_nxt;
    end
  end

  assign y_out   = r_y_out;
  assign y_wr_en = r_y_wr_en;

endmodule
`default_nettype wire

// File: tb/tb_iir.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module      : tb_iir                                                   |
// | Description : Self-checking bench for iir with a sample-level          |
// |               reference filter, FIFO models and directed scenarios.    |
// |               Honours IIR_SATURATE_EN when the design is built with it.|
// | Revision    : 1.0  initial release                                     |
// +------------------------------------------------------------------------+
module tb_iir;

  localparam int TAPS = 2;
  localparam int QB   = 10;

  logic        clock;
  logic        reset;
  logic [31:0] x_in;
  logic        x_empty;
  logic        x_rd_en;
  logic [31:0] y_out;
  logic        y_out_full;
  logic        y_wr_en;

  iir dut (
    .clock      (clock),
    .reset      (reset),
    .x_in       (x_in),
    .x_empty    (x_empty),
    .x_rd_en    (x_rd_en),
    .y_out      (y_out),
    .y_out_full (y_out_full),
    .y_wr_en    (y_wr_en)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Reference filter state (coefficients as plain integers)
  int XC [TAPS] = '{178, 178};
  int YC [TAPS] = '{0, -666};
  int xh [TAPS];
  int yh [TAPS];

  int src    [$];   // upstream FIFO contents
  int expq   [$];   // expected outputs in order
  int rd_cyc [$];   // cycle of each pop, for latency
  int log_q  [$];   // outputs observed in the current scenario
  int lat_q  [$];   // pop-to-write latency per sample

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;
  int n_rd     = 0;
  int n_wr     = 0;
  int starve_pct = 0;
  int full_pct   = 0;
  bit force_full = 1'b0;

  task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  function automatic int deq(int v);
    if (v < 0) return -((-v) >>> QB);
    return v >>> QB;
  endfunction

  function automatic int sat(int v);
`ifdef IIR_SATURATE_EN
    if (v > 32767)  return 32767;
    if (v < -32768) return -32768;
`endif
    return v;
  endfunction

  // One input sample through the reference difference equation
  task automatic model_sample(input int x);
    int acc;
    int w;
    for (int i = TAPS - 1; i > 0; i--) xh[i] = xh[i-1];
    xh[0] = x;
    acc = 0;
    for (int i = 0; i < TAPS; i++) begin
      acc += deq(XC[i] * xh[i]);
      if (i > 0) acc += deq(YC[i] * yh[i]);
    end
    w = sat(acc);
    for (int i = TAPS - 1; i > 1; i--) yh[i] = yh[i-1];
    yh[1] = w;
    expq.push_back(w);
  endtask

  // One clock: drive FIFO flags, observe pop mid-cycle, observe write after edge
  task automatic tick();
    bit avail;
    int e;
    avail      = (src.size() > 0) && ($urandom_range(0, 99) >= starve_pct);
    x_empty    = !avail;
    x_in       = avail ? src[0] : $urandom();
    y_out_full = force_full || ($urandom_range(0, 99) < full_pct);
    @(negedge clock);
    if (x_rd_en) begin
      n_rd++;
      chk("rd_en_while_empty", x_empty, 0);
      if (src.size() > 0) begin
        model_sample(src.pop_front());
        rd_cyc.push_back(cyc);
      end
    end
    @(posedge clock);
    #1;
    cyc++;
    if (y_wr_en) begin
      n_wr++;
      if (expq.size() == 0) begin
        chk("spurious_wr_en", 1, 0);
      end else begin
        e = expq.pop_front();
        chk("y_out", y_out, e);
        log_q.push_back(y_out);
        if (rd_cyc.size() > 0) lat_q.push_back(cyc - rd_cyc.pop_front());
      end
    end
  endtask

  task automatic drain(input int max_cycles);
    int k;
    k = 0;
    while ((src.size() > 0 || expq.size() > 0) && k < max_cycles) begin
      tick();
      k++;
    end
    chk("drain_timeout", (k < max_cycles) ? 0 : 1, 0);
  endtask

  task automatic do_reset(input int n);
    reset      = 1'b1;
    x_empty    = 1'b0;
    x_in       = $urandom();
    y_out_full = 1'b0;
    repeat (n) begin
      @(negedge clock);
      chk("rst_rd_en", x_rd_en, 0);
      @(posedge clock);
      #1;
      cyc++;
      chk("rst_wr_en", y_wr_en, 0);
      chk("rst_y_out", y_out, 0);
    end
    reset = 1'b0;
    for (int i = 0; i < TAPS; i++) begin
      xh[i] = 0;
      yh[i] = 0;
    end
    src.delete();
    expq.delete();
    rd_cyc.delete();
    log_q.delete();
    lat_q.delete();
  endtask

  initial begin
    int rd0;
    int wr0;
    int k;
    reset      = 1'b1;
    x_in       = '0;
    x_empty    = 1'b1;
    y_out_full = 1'b0;

    // Reset state
    do_reset(3);

    // Impulse response with free-flowing FIFOs
    src = '{1024, 0, 0};
    drain(100);
    chk("impulse_n", log_q.size(), 3);
    chk("impulse0", log_q[0], 178);
    chk("impulse1", log_q[1], 63);
    chk("impulse2", log_q[2], -40);
    foreach (lat_q[i]) chk("latency", lat_q[i], TAPS + 2);

    // Step response from cleared history
    do_reset(1);
    src = '{1024, 1024};
    drain(100);
    chk("step0", log_q[0], 178);
    chk("step1", log_q[1], 241);

    // Downstream backpressure holds the result and blocks further pops
    do_reset(1);
    src = '{1024, 512};
    force_full = 1'b1;
    rd0 = n_rd;
    wr0 = n_wr;
    repeat (12) tick();
    chk("bp_pops", n_rd - rd0, 1);
    chk("bp_writes", n_wr - wr0, 0);
    chk("bp_src_left", src.size(), 1);
    force_full = 1'b0;
    tick();
    chk("bp_release_one", n_wr - wr0, 1);
    chk("bp_first", log_q[0], 178);
    drain(100);
    chk("bp_writes_total", n_wr - wr0, 2);
    chk("bp_second", log_q[1], 152);

    // Reset in the middle of COMPUTE discards the partial sample
    do_reset(1);
    src = '{1024};
    rd0 = n_rd;
    k = 0;
    while (n_rd == rd0 && k < 10) begin
      tick();
      k++;
    end
    chk("mid_pop_seen", n_rd - rd0, 1);
    tick();
    chk("mid_wr_en_before_rst", y_wr_en, 0);
    do_reset(1);
    src = '{1024};
    drain(100);
    chk("mid_after_rst", log_q[0], 178);

    // Saturation (or plain wrap-free pass-through) of a large input
    do_reset(1);
    src = '{200000};
    drain(100);
`ifdef IIR_SATURATE_EN
    chk("sat_large", log_q[0], 32767);
`else
    chk("sat_large", log_q[0], 34765);
`endif

    // Randomized traffic with starved input and intermittent backpressure
    do_reset(2);
    for (int i = 0; i < 1000; i++) begin
      if ($urandom_range(0, 7) == 0) src.push_back(int'($urandom()));
      else                           src.push_back(int'($urandom_range(0, 2097151)) - 1048576);
    end
    starve_pct = 40;
    full_pct   = 30;
    rd0 = n_rd;
    wr0 = n_wr;
    drain(30000);
    starve_pct = 0;
    full_pct   = 0;
    repeat (8) tick();
    chk("rand_pops", n_rd - rd0, 1000);
    chk("rand_wr_eq_rd", n_wr - wr0, n_rd - rd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
